// File: rtl/router_input_channel_mvc.sv
// rtl/router_input_channel_mvc.sv - multi-VC router input channel with phase-multiplexed output
//
// Buffers upstream flits in NUM_VC FIFOs of DEPTH entries each. The VC field of each
// flit selects its FIFO. A free-running phase counter picks one VC per cycle to pop.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   send       upstream flit valid this cycle
//   data_in    flit; VC = data_in[VC_LSB +: VC_W]
//   ready      per-VC: FIFO can accept a flit (from registered count only)
//   blocked    per-VC: downstream cannot take this VC
//   phase      VC served at the next clock edge
//   out_valid  data_out holds a flit popped at the last edge
//   out_vc     VC served at the last edge
//   data_out   popped flit, or 0 when out_valid = 0
//   overflow   sticky: a flit was sent to a full VC and dropped
module router_input_channel_mvc #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_VC     = 2,
    parameter int DEPTH      = 4,
    parameter int VC_LSB     = 63,
    localparam int VC_W      = $clog2(NUM_VC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  send,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [NUM_VC-1:0]     ready,
    input  logic [NUM_VC-1:0]     blocked,
    output logic [VC_W-1:0]       phase,
    output logic                  out_valid,
    output logic [VC_W-1:0]       out_vc,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem    [NUM_VC][DEPTH];
    logic [PTR_W-1:0]      wr_ptr [NUM_VC];
    logic [PTR_W-1:0]      rd_ptr [NUM_VC];
    logic [CNT_W-1:0]      count  [NUM_VC];

    logic [VC_W-1:0] wr_vc;
    logic            push;
    logic            pop;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign wr_vc = data_in[VC_LSB +: VC_W];

    always_comb begin
        ready = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            ready[v] = (count[v] != FULL);
        end
    end

    // Both decisions use pre-edge counts: a pop this cycle never frees room for a
    // push this cycle, and a push into an empty FIFO is not poppable until later.
    assign push = send && ready[wr_vc];
    assign pop  = (count[phase] != '0) && !blocked[phase];

    // Storage carries no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_vc][wr_ptr[wr_vc]] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase     <= '0;
            out_valid <= 1'b0;
            out_vc    <= '0;
            data_out  <= '0;
            overflow  <= 1'b0;
            for (int v = 0; v < NUM_VC; v++) begin
                count[v]  <= '0;
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
            end
        end else begin
            // NUM_VC is a power of two, so natural rollover wraps NUM_VC-1 -> 0.
            phase  <= phase + 1'b1;
            out_vc <= phase;

            if (pop) begin
                out_valid     <= 1'b1;
                data_out      <= mem[phase][rd_ptr[phase]];
                rd_ptr[phase] <= next_ptr(rd_ptr[phase]);
            end else begin
                out_valid <= 1'b0;
                data_out  <= '0;
            end

            if (push) begin
                wr_ptr[wr_vc] <= next_ptr(wr_ptr[wr_vc]);
            end

            if (send && !ready[wr_vc]) begin
                overflow <= 1'b1;
            end

            for (int v = 0; v < NUM_VC; v++) begin
                if (push && (wr_vc == VC_W'(v)) && !(pop && (phase == VC_W'(v)))) begin
                    count[v] <= count[v] + 1'b1;
                end else if (!(push && (wr_vc == VC_W'(v))) && pop && (phase == VC_W'(v))) begin
                    count[v] <= count[v] - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_input_channel_mvc.sv
// tb/tb_router_input_channel_mvc.sv - randomized and directed bench for router_input_channel_mvc
module tb_router_input_channel_mvc;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        send;
    logic [63:0] din;
    logic [3:0]  blk;

    logic [1:0]  ready2;
    logic [0:0]  phase2;
    logic        ov2;
    logic [0:0]  ovc2;
    logic [63:0] dout2;
    logic        ovf2;

    logic [3:0]  ready4;
    logic [1:0]  phase4;
    logic        ov4;
    logic [1:0]  ovc4;
    logic [63:0] dout4;
    logic        ovf4;

    always #5 clk = ~clk;

    router_input_channel_mvc dut2 (
        .clk(clk), .reset(rst | sel), .send(send & ~sel), .data_in(din),
        .ready(ready2), .blocked(blk[1:0]), .phase(phase2), .out_valid(ov2),
        .out_vc(ovc2), .data_out(dout2), .overflow(ovf2)
    );

    router_input_channel_mvc #(.DATA_WIDTH(64), .NUM_VC(4), .DEPTH(3), .VC_LSB(62)) dut4 (
        .clk(clk), .reset(rst | ~sel), .send(send & sel), .data_in(din),
        .ready(ready4), .blocked(blk), .phase(phase4), .out_valid(ov4),
        .out_vc(ovc4), .data_out(dout4), .overflow(ovf4)
    );

    logic [3:0]  ready_m;
    logic [1:0]  phase_m;
    logic        ov_m;
    logic [1:0]  ovc_m;
    logic [63:0] dout_m;
    logic        ovf_m;

    always_comb begin
        ready_m = sel ? ready4 : {2'b00, ready2};
        phase_m = sel ? phase4 : {1'b0, phase2};
        ov_m    = sel ? ov4 : ov2;
        ovc_m   = sel ? ovc4 : {1'b0, ovc2};
        dout_m  = sel ? dout4 : dout2;
        ovf_m   = sel ? ovf4 : ovf2;
    end

    // Reference model: one queue per VC, a cycle index mod nv as the phase.
    int          nv;
    int          depth;
    logic [63:0] q [4][$];
    int          ph;
    logic        m_ovf;
    logic        m_valid;
    int          m_vc;
    logic [63:0] m_data;
    bit          model_live;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int vc, input logic [63:0] pl);
        logic [63:0] r;
        r = pl;
        if (nv == 2) r[63] = vc[0];
        else         r[63:62] = vc[1:0];
        return r;
    endfunction

    function automatic int vc_of(input logic [63:0] d);
        return (nv == 2) ? int'(d[63]) : int'(d[63:62]);
    endfunction

    task automatic step(input logic s, input logic [63:0] d, input logic [3:0] b, input logic r);
        int  p;
        int  vc;
        bit  acc;
        @(negedge clk);
        send = s;
        din  = d;
        blk  = b;
        rst  = r;
        #1;
        if (model_live) begin
            for (int v = 0; v < nv; v++) begin
                check_eq($sformatf("ready%0d", v), 64'(ready_m[v]), 64'(q[v].size() != depth));
            end
            check_eq("phase", 64'(phase_m), 64'(ph));
        end
        @(posedge clk);
        #1;
        if (r) begin
            for (int v = 0; v < 4; v++) q[v].delete();
            ph = 0; m_ovf = 1'b0; m_valid = 1'b0; m_vc = 0; m_data = '0;
            model_live = 1'b1;
        end else begin
            p   = ph;
            vc  = vc_of(d);
            acc = (q[vc].size() < depth);
            m_vc = p;
            if (q[p].size() != 0 && !b[p]) begin
                m_valid = 1'b1;
                m_data  = q[p].pop_front();
            end else begin
                m_valid = 1'b0;
                m_data  = '0;
            end
            if (s) begin
                if (acc) q[vc].push_back(d);
                else     m_ovf = 1'b1;
            end
            ph = (ph + 1) % nv;
        end
        if (model_live) begin
            check_eq("out_valid", 64'(ov_m), 64'(m_valid));
            check_eq("out_vc", 64'(ovc_m), 64'(m_vc));
            check_eq("data_out", dout_m, m_data);
            check_eq("overflow", 64'(ovf_m), 64'(m_ovf));
        end
    endtask

    task automatic idle(input int n, input logic [3:0] b);
        for (int i = 0; i < n; i++) step(1'b0, 64'h0, b, 1'b0);
    endtask

    task automatic align_phase0(input logic [3:0] b);
        for (int i = 0; i < 4 && ph != 0; i++) step(1'b0, 64'h0, b, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 64'h0, 4'h0, 1'b1);
        step(1'b0, 64'h0, 4'h0, 1'b1);
    endtask

    // Fill one VC past capacity while blocked, then release it.
    task automatic fill_and_drain(input int vc);
        logic [3:0] b;
        b = 4'(1 << vc);
        for (int i = 0; i <= depth; i++) step(1'b1, mk(vc, 64'h1000 + 64'(i)), b, 1'b0);
        idle(3, b);
        idle(2 * nv * depth + 2, 4'h0);
    endtask

    task automatic random_run(input int n);
        logic [63:0] pl;
        logic [3:0]  b;
        for (int i = 0; i < n; i++) begin
            pl = {$urandom, $urandom};
            b  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            step($urandom_range(0, 9) < 6, mk($urandom_range(0, nv - 1), pl), b, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; send = 1'b0; din = '0; blk = '0;
        model_live = 1'b0;
        nv = 2; depth = 4;
        for (int v = 0; v < 4; v++) q[v].delete();

        // Reset and idle: phase toggles, outputs quiet.
        do_reset();
        idle(4, 4'h0);

        // Single flit latency on VC0.
        align_phase0(4'h0);
        step(1'b1, 64'h0000_0000_0000_FA50, 4'h0, 1'b0);
        idle(3, 4'h0);

        // Fill VC1 while blocked, overflow, then drain in order.
        fill_and_drain(1);

        // Interleaved VCs.
        step(1'b1, 64'h0000_0000_0000_6840, 4'h0, 1'b0);
        step(1'b1, 64'h8000_0000_0000_C7D4, 4'h0, 1'b0);
        step(1'b1, 64'h0000_0000_0000_FFFF, 4'h0, 1'b0);
        step(1'b1, 64'h8000_0000_FFFF_FFFF, 4'h0, 1'b0);
        idle(6, 4'h0);

        // VC0 blocked while both hold data.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, mk(0, 64'h2000 + 64'(i)), 4'h1, 1'b0);
            step(1'b1, mk(1, 64'h3000 + 64'(i)), 4'h1, 1'b0);
        end
        idle(6, 4'h1);
        idle(8, 4'h0);

        // Reset with flits buffered.
        for (int i = 0; i < 3; i++) step(1'b1, mk(i % 2, 64'h4000 + 64'(i)), 4'h3, 1'b0);
        step(1'b0, 64'h0, 4'h3, 1'b1);
        idle(6, 4'h0);

        random_run(600);

        // Four VCs, DEPTH 3.
        sel = 1'b1; nv = 4; depth = 3; model_live = 1'b0;
        do_reset();
        idle(6, 4'h0);
        fill_and_drain(1);
        fill_and_drain(3);
        for (int i = 0; i < 8; i++) step(1'b1, mk(i % 4, 64'h5000 + 64'(i)), 4'h0, 1'b0);
        idle(12, 4'h0);
        random_run(800);
        do_reset();
        idle(2, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
